// File: rtl/projectile_pkg.sv
// Shared types for the projectile pool: travel direction, slot state and
// the slot-index width helper.
package projectile_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_FLYING = 1'b1
    } slot_state_t;

    localparam int COORD_W = 10;

    // Index width never drops below one bit, even for a single-slot pool.
    function automatic int SLOT_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/projectile_pool_if.sv
// Shooter/collision/render side bundle of the projectile pool.
// The master drives fire/kill/pixel coordinates; the pool (slave) returns status.
interface projectile_pool_if
    import projectile_pkg::*;
#(
    parameter int NUM_SLOTS = 4
);
    localparam int IDX_W = SLOT_IDX_W(NUM_SLOTS);

    logic                         fire_req;
    logic [1:0]                   fire_dir;
    logic [COORD_W-1:0]           x_origin;
    logic [COORD_W-1:0]           y_origin;
    logic [NUM_SLOTS-1:0]         kill;
    logic                         kill_all;
    logic [COORD_W-1:0]           x;
    logic [COORD_W-1:0]           y;
    logic                         fire_ack;
    logic [NUM_SLOTS-1:0]         slot_active;
    logic [COORD_W*NUM_SLOTS-1:0] x_pos;
    logic [COORD_W*NUM_SLOTS-1:0] y_pos;
    logic                         pixel_on;
    logic [IDX_W-1:0]             pixel_slot;

    modport master (
        output fire_req, fire_dir, x_origin, y_origin, kill, kill_all, x, y,
        input  fire_ack, slot_active, x_pos, y_pos, pixel_on, pixel_slot
    );

    modport slave (
        input  fire_req, fire_dir, x_origin, y_origin, kill, kill_all, x, y,
        output fire_ack, slot_active, x_pos, y_pos, pixel_on, pixel_slot
    );

endinterface

// File: rtl/projectile_slot.sv
// One projectile: IDLE/FLYING state, latched direction, position, exit and pixel test.
// Define PROJ_BOUNCE_EN to let a projectile reflect once off the playfield edge.
module projectile_slot
    import projectile_pkg::*;
#(
    parameter int SPEED = 4,
    parameter int SIZE  = 4,
    parameter int X_MIN = 28,
    parameter int X_MAX = 607,
    parameter int Y_MIN = 28,
    parameter int Y_MAX = 447
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_tick,
    input  logic               i_launch,
    input  logic               i_kill,
    input  dir_t               i_dir,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_px,
    input  logic [COORD_W-1:0] i_py,
    output logic               o_active,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_hit
);
    slot_state_t        r_state;
    dir_t               r_dir;
    logic [COORD_W-1:0] r_x, r_y;
`ifdef PROJ_BOUNCE_EN
    logic               r_bounced;
`endif

    logic               w_exit;
    logic [COORD_W-1:0] w_nx, w_ny;

    // Lower-bound tests compare before subtracting so a 10-bit wrap never fakes a legal position.
    always_comb begin
        w_exit = 1'b0;
        w_nx   = r_x;
        w_ny   = r_y;
        case (r_dir)
            DIR_UP: begin
                w_exit = r_y < COORD_W'(Y_MIN + SPEED);
                w_ny   = r_y - COORD_W'(SPEED);
            end
            DIR_DOWN: begin
                w_exit = ({1'b0, r_y} + 11'(SPEED)) > 11'(Y_MAX);
                w_ny   = r_y + COORD_W'(SPEED);
            end
            DIR_LEFT: begin
                w_exit = r_x < COORD_W'(X_MIN + SPEED);
                w_nx   = r_x - COORD_W'(SPEED);
            end
            DIR_RIGHT: begin
                w_exit = ({1'b0, r_x} + 11'(SPEED)) > 11'(X_MAX);
                w_nx   = r_x + COORD_W'(SPEED);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SLOT_IDLE;
            r_dir     <= DIR_UP;
            r_x       <= '0;
            r_y       <= '0;
`ifdef PROJ_BOUNCE_EN
            r_bounced <= 1'b0;
`endif
        end else if (r_state == SLOT_FLYING) begin
            if (i_kill) begin
                r_state <= SLOT_IDLE;
            end else if (i_tick) begin
                if (!w_exit) begin
                    r_x <= w_nx;
                    r_y <= w_ny;
                end
`ifdef PROJ_BOUNCE_EN
                else if (!r_bounced) begin
                    // Reverse along the same axis and park on the violated bound.
                    r_bounced <= 1'b1;
                    r_dir     <= dir_t'(r_dir ^ 2'b01);
                    case (r_dir)
                        DIR_UP:   r_y <= COORD_W'(Y_MIN);
                        DIR_DOWN: r_y <= COORD_W'(Y_MAX);
                        DIR_LEFT: r_x <= COORD_W'(X_MIN);
                        default:  r_x <= COORD_W'(X_MAX);
                    endcase
                end
`endif
                else begin
                    r_state <= SLOT_IDLE;
                end
            end
        end else if (i_launch) begin
            r_state   <= SLOT_FLYING;
            r_dir     <= i_dir;
            r_x       <= i_x0;
            r_y       <= i_y0;
`ifdef PROJ_BOUNCE_EN
            r_bounced <= 1'b0;
`endif
        end
    end

    logic [COORD_W:0] w_px, w_py, w_xl, w_yt;
    assign w_px = {1'b0, i_px};
    assign w_py = {1'b0, i_py};
    assign w_xl = {1'b0, r_x};
    assign w_yt = {1'b0, r_y};

    assign o_active = (r_state == SLOT_FLYING);
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_hit    = o_active
                   && (w_px >= w_xl) && (w_px <= w_xl + 11'(SIZE - 1))
                   && (w_py >= w_yt) && (w_py <= w_yt + 11'(SIZE - 1));

endmodule

// File: rtl/projectile_pool.sv
// Pool of NUM_SLOTS projectiles: fire allocator, cooldown, per-slot movers, pixel priority.
// Define PROJ_BOUNCE_EN to enable the single-reflection projectile variant.
module projectile_pool
    import projectile_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SPEED     = 4,
    parameter int SIZE      = 4,
    parameter int OFFSET    = 14,
    parameter int X_MIN     = 28,
    parameter int X_MAX     = 607,
    parameter int Y_MIN     = 28,
    parameter int Y_MAX     = 447,
    parameter int COOLDOWN  = 8
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic refresh_tick,
    projectile_pool_if.slave pool_if
);
    localparam int IDX_W = SLOT_IDX_W(NUM_SLOTS);
    localparam int CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    logic [CD_W-1:0]                     r_cd;
    logic                                r_fire_ack;
    logic [NUM_SLOTS-1:0]                w_active, w_hit;
    logic [NUM_SLOTS-1:0][COORD_W-1:0]   w_x, w_y;
    logic                                w_free_any, w_accept;
    logic [IDX_W-1:0]                    w_sel, w_pix_sel;
    logic [COORD_W-1:0]                  w_x0, w_y0;

    // Lowest-index idle slot; uses registered state so a slot killed this cycle stays unavailable.
    always_comb begin
        w_free_any = 1'b0;
        w_sel      = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!w_active[i]) begin
                w_free_any = 1'b1;
                w_sel      = IDX_W'(i);
            end
        end
    end

    assign w_accept = refresh_tick && pool_if.fire_req && (r_cd == '0)
                   && w_free_any && !pool_if.kill_all;
    assign w_x0     = pool_if.x_origin + COORD_W'(OFFSET);
    assign w_y0     = pool_if.y_origin + COORD_W'(OFFSET);

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_cd       <= '0;
            r_fire_ack <= 1'b0;
        end else begin
            r_fire_ack <= w_accept;
            if (w_accept)
                r_cd <= CD_W'(COOLDOWN);
            else if (refresh_tick && r_cd != '0)
                r_cd <= r_cd - 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        projectile_slot #(
            .SPEED(SPEED), .SIZE(SIZE),
            .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
        ) u_slot (
            .clk      (clk_50MHz),
            .rst_n    (reset),
            .i_tick   (refresh_tick),
            .i_launch (w_accept && (w_sel == IDX_W'(g))),
            .i_kill   (pool_if.kill[g] || pool_if.kill_all),
            .i_dir    (dir_t'(pool_if.fire_dir)),
            .i_x0     (w_x0),
            .i_y0     (w_y0),
            .i_px     (pool_if.x),
            .i_py     (pool_if.y),
            .o_active (w_active[g]),
            .o_x      (w_x[g]),
            .o_y      (w_y[g]),
            .o_hit    (w_hit[g])
        );
    end

    always_comb begin
        w_pix_sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_hit[i])
                w_pix_sel = IDX_W'(i);
        end
    end

    assign pool_if.fire_ack    = r_fire_ack;
    assign pool_if.slot_active = w_active;
    assign pool_if.x_pos       = w_x;
    assign pool_if.y_pos       = w_y;
    assign pool_if.pixel_on    = |w_hit;
    assign pool_if.pixel_slot  = w_pix_sel;

endmodule

// File: doc/projectile_pool.md
Name: projectile_pool

Overview:
Manages a pool of NUM_SLOTS independent projectiles for one shooter (tank or enemy). It allocates a free slot on a fire request, advances every live projectile once per refresh_tick, and retires projectiles on playfield exit or external kill. It also drives per-pixel hit flags to the VGA colour mux. It sits between a shooter block (origin, direction, fire request) and the collision/render logic.

Parameters:
NUM_SLOTS, 4, number of concurrent projectiles (1..8)
SPEED, 4, pixels moved per refresh_tick
SIZE, 4, projectile square edge in pixels
OFFSET, 14, added to origin x/y at launch (centres on 32x32 sprite)
X_MIN, 28, lowest legal projectile x_l
X_MAX, 607, highest legal projectile x_l
Y_MIN, 28, lowest legal projectile y_t
Y_MAX, 447, highest legal projectile y_t
COOLDOWN, 8, refresh_ticks after an accepted fire before the next can be accepted

Ports:
clk_50MHz  in  1  system clock
reset  in  1  asynchronous, active-low reset
refresh_tick  in  1  one-cycle frame-rate strobe
x  in  10  VGA pixel column
y  in  10  VGA pixel row
fire_req  in  1  fire request, level, sampled only on refresh_tick
fire_dir  in  2  00 up, 01 down, 10 left, 11 right
x_origin  in  10  shooter x_l
y_origin  in  10  shooter y_t
kill  in  NUM_SLOTS  per-slot retire request (hit detected)
kill_all  in  1  retire every slot (shooter destroyed)
fire_ack  out  1  one-cycle pulse: request accepted
slot_active  out  NUM_SLOTS  slot i in FLYING
x_pos  out  10*NUM_SLOTS  packed x_l, slot i at [10i+9:10i]
y_pos  out  10*NUM_SLOTS  packed y_t
pixel_on  out  1  (x,y) inside any active projectile
pixel_slot  out  $clog2(NUM_SLOTS) (min 1)  lowest active slot index hit by (x,y); 0 when pixel_on=0

Behaviour:
- Reset (async, reset=0): all slots IDLE; x_pos/y_pos = 0; cooldown = 0; fire_ack = 0; all outputs 0.
- Per-slot FSM, IDLE -> FLYING -> IDLE; direction latched at launch.
- Fire, on a cycle with refresh_tick=1, fire_req=1, cooldown=0 and at least one IDLE slot:
  - Lowest-index IDLE slot goes FLYING next edge; pos = origin+OFFSET (10-bit add).
  - fire_ack=1 for exactly that cycle (registered, visible the following cycle); cooldown loads COOLDOWN.
- Pool full or cooldown!=0: request dropped silently, never queued, no ack.
- Cooldown decrements by 1 on each refresh_tick while nonzero; saturates at 0.
- Movement, on refresh_tick, for each FLYING slot not launched this tick:
  - Compute next = pos ± SPEED along the latched direction.
  - Exit test uses pre-subtract compare to avoid 10-bit wrap. Up exits if y_t < Y_MIN+SPEED; down exits if y_t+SPEED > Y_MAX. Left/right use the same form on x.
  - On exit: slot -> IDLE, pos held. Otherwise pos <= next.
  - A newly launched slot first moves on the following refresh_tick.
- Kill:
  - kill[i] or kill_all in any cycle (tick not required) forces slot -> IDLE at next edge.
  - Kill has priority over movement and over exit.
  - Kill of an IDLE slot is ignored.
  - A slot freed this cycle is not allocatable until the next refresh_tick.
  - A same-cycle fire with kill_all=1 is rejected (no ack).
- Position outputs of IDLE slots hold their last value; consumers must qualify with slot_active.
- Pixel test is combinational: x_l <= x <= x_l+SIZE-1 and y_t <= y <= y_t+SIZE-1, active slots only.

Optional Feature:
PROJ_BOUNCE_EN:
- Defined: each projectile may reflect once. On the first exit it reverses direction and is clamped to the violated bound (e.g. up -> y_t = Y_MIN, dir = down). It retires only on the second exit. A per-slot bounced bit clears at launch.
- Undefined: retire on first exit; no bounced bit.

Decomposition:
- Package projectile_pkg: dir_t enum (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT = 2'b00..11); slot_state_t enum (SLOT_IDLE, SLOT_FLYING); SLOT_IDX_W helper function.
- Sub-module projectile_slot: one slot's FSM, position registers, exit test and pixel test. The pool instantiates it in a generate loop and adds the allocator, cooldown and pixel priority encoder.

Test Plan:
1. Reset, then fire_req=1, dir=00, origin (100,200) on a tick -> fire_ack one cycle; slot0 active at (114,214); next tick (114,210).
2. Hold fire_req with COOLDOWN=8 -> acks exactly 9 ticks apart; slots 0,1,2,3 filled in order; 5th request while full -> no ack.
3. dir=10 from origin (20,100), x_l=34 -> moves to 30, then exit (30<32) -> slot IDLE, x_pos holds 30; with PROJ_BOUNCE_EN -> x_l=28, dir=right, slot still active.
4. kill[1] mid-frame with no tick -> slot1 IDLE next edge. kill_all coincident with a fire tick -> all IDLE, no ack.
5. Two active slots overlapping at pixel (120,120) -> pixel_on=1, pixel_slot=lowest index; pixel outside both -> 0, 0.
6. Assert reset mid-flight -> immediate all-zero outputs; after release first fire goes to slot0 with cooldown 0.
